// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive sampler.
// Majority voting is selected with the UART_RX_MAJORITY_EN macro in the top level.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    localparam int OVERSAMPLE = 16;

    localparam logic [3:0] MID_TICK_0 = 4'd7;
    localparam logic [3:0] MID_TICK_1 = 4'd8;
    localparam logic [3:0] MID_TICK_2 = 4'd9;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO, first-word fall-through with a registered head.
// Pointers carry one extra wrap bit to tell full from empty.
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en_i,
    input  logic [7:0] wr_data_i,
    input  logic       rd_en_i,
    output logic [7:0] rd_data_o,
    output logic       empty_o,
    output logic       full_o,
    output logic       overrun_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  head_q;
    logic        overrun_q;
    logic        do_read;
    logic        do_write;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A same-cycle pop frees the slot, so a write into a full FIFO still lands.
    assign do_read  = rd_en_i & ~empty_o;
    assign do_write = wr_en_i & (~full_o | do_read);

    assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_write);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_read);

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            head_q    <= 8'h00;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= wr_en_i & full_o & ~do_read;
            // Forward the incoming byte when it becomes the new head this cycle.
            if (wr_ptr_d != rd_ptr_d) begin
                if (do_write && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
                    head_q <= wr_data_i;
                end else begin
                    head_q <= mem[rd_ptr_d[AW-1:0]];
                end
            end
        end
    end

    assign rd_data_o = head_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front end: synchronizer, 16x oversampling FSM, shifter, break detect.
// Define UART_RX_MAJORITY_EN to vote each bit from samples at ticks 7, 8 and 9.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int BREAK_BITS = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_16x_baud_i,
    input  logic       serial_in_i,
    input  logic       msb_first_i,
    input  logic       rx_read_buffer_i,
    output logic [7:0] rx_data_o,
    output logic       rx_data_present_o,
    output logic       rx_buffer_full_o,
    output logic       rx_overrun_o,
    output logic       rx_framing_err_o,
    output logic       rx_break_o
);
    localparam int BREAK_TICKS = OVERSAMPLE * BREAK_BITS;
    localparam int LW          = $clog2(BREAK_TICKS + 1);

    logic [1:0]    sync_q;
    logic          line;
    rx_state_e     state_q, state_d;
    logic [3:0]    tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          order_q, order_d;
    logic [LW-1:0] low_cnt_q, low_cnt_d;
    logic          break_q, break_d;
    logic          frame_err_q, frame_err_d;
    logic          fifo_wr;
    logic          leave_wait;
    logic          bit_val;
    logic          decide;
    logic          fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], serial_in_i};
        end
    end
    assign line = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] smp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            smp_q <= 2'b11;
        end else if (en_16x_baud_i && (tick_q == MID_TICK_0)) begin
            smp_q[0] <= line;
        end else if (en_16x_baud_i && (tick_q == MID_TICK_1)) begin
            smp_q[1] <= line;
        end
    end

    assign bit_val = majority3(smp_q[0], smp_q[1], line);
    assign decide  = en_16x_baud_i && (tick_q == MID_TICK_2);
`else
    assign bit_val = line;
    assign decide  = en_16x_baud_i && (tick_q == MID_TICK_0);
`endif

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        order_d     = order_q;
        fifo_wr     = 1'b0;
        frame_err_d = 1'b0;
        leave_wait  = 1'b0;
        if (en_16x_baud_i) begin
            case (state_q)
                IDLE: begin
                    tick_d = 4'd0;
                    if (!line) begin
                        state_d = START;
                    end
                end
                START: begin
                    tick_d = tick_q + 4'd1;
                    if (decide) begin
                        if (bit_val) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            order_d = msb_first_i;
                            bit_d   = 3'd0;
                        end
                    end
                end
                DATA: begin
                    tick_d = tick_q + 4'd1;
                    if (decide) begin
                        shift_d = order_q ? {shift_q[6:0], bit_val} : {bit_val, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end
                end
                STOP: begin
                    tick_d = tick_q + 4'd1;
                    if (decide) begin
                        if (bit_val) begin
                            fifo_wr = ~break_q;
                            state_d = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = WAIT_IDLE;
                            tick_d      = 4'd0;
                        end
                    end
                end
                WAIT_IDLE: begin
                    // The tick counter doubles as the run length of high ticks here.
                    if (!line) begin
                        tick_d = 4'd0;
                    end else if (tick_q == 4'd15) begin
                        tick_d     = 4'd0;
                        state_d    = IDLE;
                        leave_wait = 1'b1;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tick_d  = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        low_cnt_d = low_cnt_q;
        break_d   = break_q;
        if (en_16x_baud_i) begin
            if (line) begin
                low_cnt_d = '0;
            end else if (low_cnt_q != LW'(BREAK_TICKS)) begin
                low_cnt_d = low_cnt_q + LW'(1);
            end
        end
        if (leave_wait) begin
            break_d = 1'b0;
        end else if (low_cnt_d == LW'(BREAK_TICKS)) begin
            break_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tick_q      <= 4'd0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            order_q     <= 1'b0;
            low_cnt_q   <= '0;
            break_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            order_q     <= order_d;
            low_cnt_q   <= low_cnt_d;
            break_q     <= break_d;
            frame_err_q <= frame_err_d;
        end
    end

    uart_rx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (fifo_wr),
        .wr_data_i (shift_q),
        .rd_en_i   (rx_read_buffer_i),
        .rd_data_o (rx_data_o),
        .empty_o   (fifo_empty),
        .full_o    (rx_buffer_full_o),
        .overrun_o (rx_overrun_o)
    );

    assign rx_data_present_o = ~fifo_empty;
    assign rx_framing_err_o  = frame_err_q;
    assign rx_break_o        = break_q;

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Serial receive front end of the UART core: it converts the incoming line into bytes and feeds the frame/register decoder (SOF 0xAA, command, address, burst, data). It oversamples the line with the shared 16x baud enable and supports LSB-first or MSB-first bit order. It detects glitches, framing errors and break conditions, and buffers received bytes in a small FIFO.

## Interface
- FIFO_DEPTH, 16, receive FIFO entries; power of two, ≥2
- BREAK_BITS, 11, continuous-low bit times that qualify as break
- clk  in  1  core clock
- rst  in  1  reset; synchronous and active-high
- en_16x_baud_i  in  1  single-cycle tick at 16x baud
- serial_in_i  in  1  asynchronous RX line, idle high
- msb_first_i  in  1  bit order: 1 = MSB first
- rx_read_buffer_i  in  1  pop FIFO head
- rx_data_o  out  8  FIFO head (first-word fall-through)
- rx_data_present_o  out  1  FIFO not empty
- rx_buffer_full_o  out  1  FIFO full
- rx_overrun_o  out  1  one-cycle pulse: byte dropped, FIFO full
- rx_framing_err_o  out  1  one-cycle pulse: stop bit sampled low
- rx_break_o  out  1  level: break in progress

## Operation
- Input: 2-flop synchronizer on serial_in_i, both flops reset to 1. All FSM and counter activity advances only on ticks (en_16x_baud_i=1).
- Tick counter: 4 bits, wraps 15→0. Bit counter: 3 bits.
- IDLE: on a tick with synced line 0, clear the tick counter and go to START.
- START: at tick count 7 (mid-bit), sample the line.
  - Line high: glitch, return to IDLE with no flags.
  - Line low: latch msb_first_i for the whole frame and go to DATA.
- DATA: sample at each mid-bit (16 ticks apart). Eight bits are taken.
  - LSB-first: shift right, inserting at bit 7.
  - MSB-first: shift left, inserting at bit 0.
- STOP: sample at mid-bit.
  - Stop bit high: write the byte to the FIFO and return to IDLE.
  - Stop bit low: pulse rx_framing_err_o, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: return to IDLE after 16 consecutive ticks with the line high. Any low tick restarts this count.
- Break: a low-run counter counts consecutive low ticks from the start edge.
  - rx_break_o sets when the count reaches 16*BREAK_BITS. The counter saturates there.
  - rx_break_o clears on the same cycle the FSM leaves WAIT_IDLE.
  - No byte is written during a break.
- FIFO write with FIFO full: the byte is dropped and rx_overrun_o pulses.
  - Exception: a same-cycle rx_read_buffer_i pops first, so the write succeeds and there is no overrun.
- Read while empty is ignored. Pointers wrap modulo FIFO_DEPTH, with one extra bit to tell full from empty.

## Timing
- Reset values: FSM IDLE, FIFO empty, all counters 0.
  - rx_data_o=0x00; rx_data_present_o, rx_buffer_full_o, rx_overrun_o, rx_framing_err_o and rx_break_o all 0.
- Reset mid-frame abandons the frame immediately. Outputs return to reset values on the next edge.
- Latency from line edge to start detection: 2 clk (synchronizer) plus the next tick.
- rx_data_present_o and the new rx_data_o are valid 1 clk after the stop mid-bit tick.
- Error and overrun pulses are registered, 1 clk after the deciding tick.
- rx_data_o updates 1 clk after a pop.

## Configuration
- UART_RX_MAJORITY_EN defined: each bit (start, data, stop) is the 2-of-3 majority of samples at tick counts 7, 8 and 9. The decision is made at tick 9 and the bit boundary is unchanged.
- Not defined: a single sample at tick count 7. All other behaviour is identical.

## Structure
- Package uart_rx_pkg holds:
  - state encoding: IDLE, START, DATA, STOP, WAIT_IDLE
  - OVERSAMPLE=16
  - mid-sample tick constants (7, 8, 9)
- Sub-module uart_rx_fifo: synchronous FIFO, FWFT, parameterized by FIFO_DEPTH. It exposes full, empty and an overrun pulse.
- The top level contains the synchronizer, FSM, shifter and break counter.

## Test plan
- LSB-first 0x91 (line: 0,1,0,0,0,1,0,0,1,1, 16 ticks per bit) → rx_data_o=0x91; rx_data_present_o high 1 clk after the stop mid-tick.
- msb_first_i=1, send 0xAA then 0x91 MSB-first → reads 0xAA, 0x91. The same 0x91 waveform with msb_first_i=0 → 0x89.
- Line low 4 ticks then high → no FIFO write, no flags, FSM back in IDLE.
- Send 0x91, then force the line low after 2 bit times for 20 bit times:
  - rx_framing_err_o pulses exactly once.
  - rx_break_o rises 176 ticks after the start edge and falls 16 ticks after release.
  - No FIFO write.
  - A following 0xAA frame is received correctly.
- 17 bytes 0x01..0x11 with no reads:
  - rx_buffer_full_o high after the 16th byte.
  - The 17th byte gives an rx_overrun_o pulse.
  - Reads return 0x01..0x10 in order.
  - A full FIFO with read and write in the same cycle → no overrun.
- Assert rst at DATA bit 4 → all outputs at reset values. The next frame, 0x55, is received correctly.
